sw_run_sequencer: RTL

SW_RUN_SEQUENCER -- requirements
Module: sw_run_sequencer

---
 rtl/sw_run_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/sw_run_sequencer.sv
// Sequences one or two aligner-core runs: optional set-t handshake, then per run
// load the score word, pulse start, capture the result and wait for the core to go idle.
module sw_run_sequencer #(
  parameter int unsigned RESULT_W = 16,
  parameter int unsigned TIMEOUT  = 50000000,
  parameter int unsigned CNT_W    = 26
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_go,
  input  logic                i_skip_set,
  input  logic [15:0]         i_param0,
  input  logic [15:0]         i_param1,
  output logic                o_set_t,
  output logic                o_start_cal,
  output logic [3:0]          o_match,
  output logic [3:0]          o_mismatch,
  output logic [3:0]          o_minusAlpha,
  output logic [3:0]          o_minusBeta,
  input  logic                i_busy,
  input  logic                i_valid,
  input  logic [RESULT_W-1:0] i_result,
  output logic [RESULT_W-1:0] o_result0,
  output logic [RESULT_W-1:0] o_result1,
  output logic                o_seq_busy,
  output logic                o_done,
  output logic                o_error
);

  typedef enum logic [2:0] {
    StIdle, StSetT, StWaitSet, StLoad, StStart, StWaitValid, StWaitIdle, StDone
  } state_e;

  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                run_q, run_d;
  logic [15:0]         param0_q, param0_d;
  logic [15:0]         param1_q, param1_d;
  logic [15:0]         score_q, score_d;
  logic [RESULT_W-1:0] result0_q, result0_d;
  logic [RESULT_W-1:0] result1_q, result1_d;
  logic                error_q, error_d;
  logic                timeout_hit;
  logic                in_wait;

  assign timeout_hit = (cnt_q == TimeoutLast);
  assign in_wait = (state_q == StWaitSet) || (state_q == StWaitValid) ||
                   (state_q == StWaitIdle);

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    param0_d  = param0_q;
    param1_d  = param1_q;
    score_d   = score_q;
    result0_d = result0_q;
    result1_d = result1_q;
    error_d   = error_q;

    case (state_q)
      StIdle: begin
        if (i_go) begin
          param0_d = i_param0;
          param1_d = i_param1;
          error_d  = 1'b0;
          run_d    = 1'b0;
          state_d  = i_skip_set ? StLoad : StSetT;
        end
      end
      StSetT: state_d = StWaitSet;
      StWaitSet: begin
        // A zero count marks the first cycle here, where busy may not yet reflect set-t.
        if (timeout_hit) begin
          error_d = 1'b1;
          state_d = StDone;
        end else if ((cnt_q != '0) && !i_busy) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        score_d = run_q ? param1_q : param0_q;
        state_d = StStart;
      end
      StStart: state_d = StWaitValid;
      StWaitValid: begin
        if (timeout_hit) begin
          error_d = 1'b1;
          state_d = StDone;
        end else if (i_valid) begin
          if (run_q) result1_d = i_result;
          else       result0_d = i_result;
          state_d = StWaitIdle;
        end
      end
      StWaitIdle: begin
        if (timeout_hit) begin
          error_d = 1'b1;
          state_d = StDone;
        end else if (!i_busy) begin
          if (run_q) begin
            state_d = StDone;
          end else begin
            run_d   = 1'b1;
            state_d = StLoad;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d != state_q) cnt_d = '0;
    else if (in_wait)       cnt_d = cnt_q + CNT_W'(1);
    else                    cnt_d = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      run_q     <= 1'b0;
      param0_q  <= '0;
      param1_q  <= '0;
      score_q   <= '0;
      result0_q <= '0;
      result1_q <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      run_q     <= run_d;
      param0_q  <= param0_d;
      param1_q  <= param1_d;
      score_q   <= score_d;
      result0_q <= result0_d;
      result1_q <= result1_d;
      error_q   <= error_d;
    end
  end

  assign o_set_t      = (state_q == StSetT);
  assign o_start_cal  = (state_q == StStart);
  assign o_seq_busy   = (state_q != StIdle);
  assign o_done       = (state_q == StDone);
  assign o_error      = error_q;
  assign o_match      = score_q[15:12];
  assign o_mismatch   = score_q[11:8];
  assign o_minusAlpha = score_q[7:4];
  assign o_minusBeta  = score_q[3:0];
  assign o_result0    = result0_q;
  assign o_result1    = result1_q;

endmodule
